// File: rtl/rv32i_dmem_pkg.sv
// Shared types and constants for the MEMORY-stage data bus bridge.
package rv32i_dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } dmem_state_e;

    localparam logic [3:0] WB_SEL_ALL = 4'b1111;

endpackage

// File: rtl/rv32i_dmem_timeout.sv
// Bus watchdog: loaded on request accept, counts down while a transfer is open.
module rv32i_dmem_timeout #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the last allowed cycle, so the bus sees exactly TIMEOUT cycles of cyc.
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == ONE);

endmodule

// File: rtl/rv32i_dmem_bridge.sv
// MEMORY-stage data bridge: one aligned request -> one Wishbone B4 pipelined single transfer.
module rv32i_dmem_bridge
    import rv32i_dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_mask,
    output logic              req_ready,
    output logic              stall_o,
    input  logic              flush_i,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic              wb_stall_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic [31:0]       wb_dat_i
);

    dmem_state_e       state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              flushed_q, flushed_d;

    logic tmo_load, tmo_en, tmo_expired;
    logic busy, bus_done;

    rv32i_dmem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmo_load),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    assign busy = (state_q == ST_REQ) || (state_q == ST_WAIT);
    // A response only counts in REQ if the strobe is being accepted that same cycle.
    assign bus_done = (wb_ack_i || wb_err_i) && ((state_q == ST_WAIT) || !wb_stall_i);

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        flushed_d = flushed_q;
        tmo_load  = 1'b0;
        tmo_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d   = ST_REQ;
                    we_d      = req_we;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    sel_d     = req_we ? req_mask : WB_SEL_ALL;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    flushed_d = 1'b0;
                    tmo_load  = 1'b1;
                end
            end
            ST_REQ, ST_WAIT: begin
                tmo_en = 1'b1;
                if (flush_i) begin
                    flushed_d = 1'b1;
                end
                if (bus_done) begin
                    state_d = ST_RESP;
                    err_d   = wb_err_i;
                    rdata_d = (wb_err_i || we_q) ? '0 : (wb_dat_i >> {addr_q[1:0], 3'b000});
                end else if (tmo_expired) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if ((state_q == ST_REQ) && !wb_stall_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            flushed_q <= flushed_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign stall_o   = busy && !flushed_q && !flush_i;
    assign rsp_valid = (state_q == ST_RESP) && !flushed_q && !flush_i;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_valid && err_q;

    assign wb_cyc_o = busy;
    assign wb_stb_o = (state_q == ST_REQ);
    assign wb_we_o  = we_q;
    assign wb_adr_o = {addr_q[ADDR_W-1:2], 2'b00};
    assign wb_dat_o = wdata_q;
    assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_rv32i_dmem_bridge.sv
// Directed bench for rv32i_dmem_bridge: vector table plus hand-written multi-cycle sequences.
module tb_rv32i_dmem_bridge;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_mask;
    logic        req_ready, stall_o, flush_i;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i, wb_ack_i, wb_err_i;
    logic [31:0] wb_dat_i;

    always #5 clk = ~clk;

    rv32i_dmem_bridge #(
        .TIMEOUT (TMO),
        .ADDR_W  (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .req_ready  (req_ready),
        .stall_o    (stall_o),
        .flush_i    (flush_i),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stall_i (wb_stall_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_dat_i   (wb_dat_i)
    );

    // mode: 0 = ack, 1 = err, 2 = ack+err; early = respond in the stb-accept cycle
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          stalls;
        int          waits;
        bit          early;
        int          mode;
        logic [31:0] slv_dat;
        logic [31:0] exp_adr;
        logic [3:0]  exp_sel;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slave;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_dat_i   = '0;
    endtask

    task automatic drive_rsp(input vec_t v);
        wb_ack_i = (v.mode != 1);
        wb_err_i = (v.mode != 0);
        wb_dat_i = v.slv_dat;
    endtask

    // Called at posedge+1 with the bridge idle; that cycle is cycle 0 (accept).
    task automatic run_txn(input vec_t v, input string tag);
        int          cyc_n, stall_left, wait_left, lat;
        bit          pending, got, stall_ok;
        logic [31:0] rd;
        logic        er;
        chk({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_mask  = v.mask;
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mask  = '0;
        cyc_n = 1; stall_left = v.stalls; wait_left = 0;
        pending = 0; got = 0; stall_ok = 1; lat = 0; rd = '0; er = 1'b0;
        while (!got && cyc_n < 40) begin
            clear_slave();
            if (rsp_valid) begin
                got = 1; lat = cyc_n; rd = rsp_rdata; er = rsp_err;
            end else begin
                if (stall_o !== 1'b1) stall_ok = 0;
                if (wb_stb_o) begin
                    if (stall_left > 0) begin
                        wb_stall_i = 1'b1;
                        stall_left--;
                    end else begin
                        chk({tag, "_adr"}, wb_adr_o, v.exp_adr);
                        chk({tag, "_sel"}, {28'd0, wb_sel_o}, {28'd0, v.exp_sel});
                        chk({tag, "_we"}, wb_we_o, v.we);
                        chk({tag, "_dat"}, wb_dat_o, v.wdata);
                        if (v.early) drive_rsp(v);
                        else begin pending = 1; wait_left = v.waits; end
                    end
                end else if (pending && wb_cyc_o) begin
                    if (wait_left > 0) wait_left--;
                    else begin drive_rsp(v); pending = 0; end
                end
                step();
                cyc_n++;
            end
        end
        chk({tag, "_rsp_seen"}, got, 1);
        if (got) begin
            chk({tag, "_lat"}, lat, v.exp_lat);
            chk({tag, "_rdata"}, rd, v.exp_rdata);
            chk({tag, "_err"}, er, v.exp_err);
            chk({tag, "_stall_hold"}, stall_ok, 1);
        end
        clear_slave();
        step();
        chk({tag, "_idle"}, {req_ready, wb_cyc_o, stall_o, rsp_valid}, 4'b1000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc_n, cyc_hi, lat;
        bit   got, any_rsp;
        logic er;

        vecs[0] = '{1'b1, 32'h104,  32'h0000AB00, 4'b0010, 0, 0, 1'b0, 0, 32'hDEADBEEF, 32'h104,  4'b0010, 32'h00000000, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h203,  32'h0,        4'b0001, 1, 2, 1'b0, 0, 32'h80FF1234, 32'h200,  4'b1111, 32'h00000080, 1'b0, 6};
        vecs[2] = '{1'b0, 32'h202,  32'h0,        4'b0011, 0, 1, 1'b0, 0, 32'h80FF1234, 32'h200,  4'b1111, 32'h000080FF, 1'b0, 4};
        vecs[3] = '{1'b0, 32'h1000, 32'h0,        4'b1111, 2, 0, 1'b0, 0, 32'hCAFEF00D, 32'h1000, 4'b1111, 32'hCAFEF00D, 1'b0, 5};
        vecs[4] = '{1'b0, 32'h301,  32'h0,        4'b0010, 0, 0, 1'b0, 2, 32'h11223344, 32'h300,  4'b1111, 32'h00000000, 1'b1, 3};
        vecs[5] = '{1'b1, 32'h40C,  32'h55AA0000, 4'b1100, 0, 0, 1'b0, 1, 32'h0,        32'h40C,  4'b1100, 32'h00000000, 1'b1, 3};
        vecs[6] = '{1'b0, 32'h105,  32'h0,        4'b0010, 0, 0, 1'b1, 0, 32'hA5B6C7D8, 32'h104,  4'b1111, 32'h00A5B6C7, 1'b0, 2};

        rst_n = 1'b0; flush_i = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_mask = '0;
        clear_slave();
        #3;
        chk("rst_ready_stall_rsp", {req_ready, stall_o, rsp_valid, rsp_err}, 4'b1000);
        chk("rst_bus_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 7'b0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: slave accepts stb then never answers.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_mask = 4'b1111;
        step();
        req_valid = 1'b0;
        cyc_n = 1; cyc_hi = 0; got = 0; lat = 0; er = 1'b0;
        while (!got && cyc_n < 30) begin
            if (rsp_valid) begin
                got = 1; lat = cyc_n; er = rsp_err;
            end else if (wb_cyc_o) begin
                cyc_hi++;
            end
            step();
            cyc_n++;
        end
        chk("tmo_rsp_seen", got, 1);
        chk("tmo_cyc_cycles", cyc_hi, TMO);
        chk("tmo_lat", lat, TMO + 1);
        chk("tmo_err", er, 1);
        wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        step();
        clear_slave();
        any_rsp = 0;
        for (int c = 0; c < 3; c++) begin
            if (rsp_valid || wb_cyc_o || !req_ready) any_rsp = 1;
            step();
        end
        chk("tmo_stray_ack_ignored", any_rsp, 0);

        // Flush during WAIT: bus completes, response suppressed.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_mask = 4'b1111;
        step();
        req_valid = 1'b0;
        any_rsp = 0;
        for (int c = 1; c <= 7; c++) begin
            clear_slave();
            flush_i = (c == 3);
            if (c == 5) begin wb_ack_i = 1'b1; wb_dat_i = 32'h12345678; end
            #1;
            if (rsp_valid) any_rsp = 1;
            if (c == 2) chk("fl_stall_before", stall_o, 1);
            if (c == 3) chk("fl_stall_same_cycle", stall_o, 0);
            if (c == 4) chk("fl_stall_after_cyc", {stall_o, wb_cyc_o}, 2'b01);
            if (c == 6) chk("fl_resp_not_ready", req_ready, 0);
            if (c == 7) chk("fl_idle_ready", req_ready, 1);
            @(posedge clk);
            #1;
        end
        flush_i = 1'b0;
        clear_slave();
        chk("fl_no_rsp_valid", any_rsp, 0);
        run_txn(vecs[0], "fl_next");

        // Asynchronous reset while stb is held off by the slave.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h1; req_mask = 4'b0001;
        step();
        req_valid = 1'b0;
        wb_stall_i = 1'b1;
        step();
        chk("ar_in_req", {wb_cyc_o, wb_stb_o}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_bus_drop", {wb_cyc_o, wb_stb_o, stall_o}, 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_slave();
        step();
        chk("ar_after_release", {req_ready, stall_o, rsp_valid}, 3'b100);
        run_txn(vecs[1], "ar_next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
